// File: rtl/downsample_ctrl_if.sv
// downsample_ctrl_if
//   Bundles the frame-source handshake and the downsample-datapath
//   signals of downsample_ctrl.
//   Source side   : req, src_data, src_vld (to controller), src_rdy, gnt (from controller)
//   Datapath side : bin_data, bin_data_vld (to datapath), down_data_vld (from datapath)
//   modport slave  - the controller's view
//   modport master - the view of whoever drives sources and datapath
interface downsample_ctrl_if;
  logic [1:0] req;
  logic [1:0] src_data;
  logic [1:0] src_vld;
  logic [1:0] src_rdy;
  logic [1:0] gnt;
  logic       bin_data;
  logic       bin_data_vld;
  logic       down_data_vld;

  modport master (
    output req, src_data, src_vld, down_data_vld,
    input  src_rdy, gnt, bin_data, bin_data_vld
  );

  modport slave (
    input  req, src_data, src_vld, down_data_vld,
    output src_rdy, gnt, bin_data, bin_data_vld
  );
endinterface

// File: rtl/downsample_ctrl.sv
// downsample_ctrl
//   Arbitrates between two binary-pixel sources (round robin), streams one
//   IMG_W x IMG_W frame from the granted source into the downsample
//   datapath, then waits for the datapath to produce its (IMG_W/4)^2
//   outputs, with a DRAIN_TO-cycle timeout.
// Ports
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   bus        - downsample_ctrl_if.slave (source handshake + datapath signals)
//   busy       - high whenever the FSM is not in IDLE
//   frame_done - one-cycle pulse in the DONE state
//   frame_src  - source index of the last completed frame
//   drain_err  - sticky drain-timeout flag, cleared only by rst
module downsample_ctrl #(
  parameter int IMG_W    = 112,
  parameter int DRAIN_TO = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  downsample_ctrl_if.slave     bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_src,
  output logic                 drain_err
);

  localparam int PIX_N = IMG_W * IMG_W;
  localparam int OUT_N = (IMG_W / 4) * (IMG_W / 4);
  localparam int PIX_W = $clog2(PIX_N + 1);
  localparam int OUT_W = $clog2(OUT_N + 1);
  localparam int TMR_W = $clog2(DRAIN_TO + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [1:0]       gnt_q;
  logic             last_srv;
  logic [PIX_W-1:0] pix_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic [OUT_W-1:0] out_cnt_nxt;
  logic [TMR_W-1:0] drain_tmr;
  logic [1:0]       rdy;
  logic [1:0]       arb_gnt;
  logic             g;
  logic             transfer;
  logic             out_cnt_en;
  logic             out_hit;
  logic             tmr_expired;
  logic             bin_data_q;
  logic             bin_data_vld_q;

  // gnt_q is one-hot, so its upper bit is the granted source index
  assign g = gnt_q[1];

  // Ready is only offered to the granted source while pixels remain
  always_comb begin
    rdy = 2'b00;
    if (state == RUN && pix_cnt < PIX_W'(PIX_N))
      rdy = gnt_q;
  end

  assign transfer = |(rdy & bus.src_vld);

  // Round robin: on contention the source not served last wins
  always_comb begin
    arb_gnt = 2'b00;
    case (bus.req)
      2'b01:   arb_gnt = 2'b01;
      2'b10:   arb_gnt = 2'b10;
      2'b11:   arb_gnt = last_srv ? 2'b01 : 2'b10;
      default: arb_gnt = 2'b00;
    endcase
  end

  // Output counting saturates at OUT_N; out_hit looks at the next value so a
  // pulse arriving in the DRAIN cycle itself completes the frame
  assign out_cnt_en  = bus.down_data_vld && (state == GRANT || state == RUN || state == DRAIN);
  assign out_cnt_nxt = (out_cnt_en && out_cnt != OUT_W'(OUT_N)) ? out_cnt + 1'b1 : out_cnt;
  assign out_hit     = (out_cnt_nxt == OUT_W'(OUT_N));
  assign tmr_expired = (drain_tmr == TMR_W'(DRAIN_TO - 1));

  // Main FSM, counters and registered datapath outputs. frame_src and the
  // last-served pointer are loaded on entry to DONE so frame_src is already
  // valid while frame_done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gnt_q          <= 2'b00;
      last_srv       <= 1'b1;
      pix_cnt        <= '0;
      out_cnt        <= '0;
      drain_tmr      <= '0;
      bin_data_q     <= 1'b0;
      bin_data_vld_q <= 1'b0;
      frame_src      <= 1'b0;
      drain_err      <= 1'b0;
    end else begin
      bin_data_vld_q <= transfer;
      bin_data_q     <= transfer ? bus.src_data[g] : 1'b0;
      out_cnt        <= out_cnt_nxt;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state   <= GRANT;
            gnt_q   <= arb_gnt;
            pix_cnt <= '0;
            out_cnt <= '0;
          end
        end
        GRANT: state <= RUN;
        RUN: begin
          drain_tmr <= '0;
          if (transfer) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == PIX_W'(PIX_N - 1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hit || tmr_expired) begin
            state     <= DONE;
            frame_src <= g;
            last_srv  <= g;
            if (!out_hit)
              drain_err <= 1'b1;
          end else begin
            drain_tmr <= drain_tmr + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt_q <= 2'b00;
        end
        default: begin
          state <= IDLE;
          gnt_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus.src_rdy      = rdy;
  assign bus.gnt          = gnt_q;
  assign bus.bin_data     = bin_data_q;
  assign bus.bin_data_vld = bin_data_vld_q;
  assign busy             = (state != IDLE);
  assign frame_done       = (state == DONE);

endmodule
